spi_mem_master: RTL

Parametrised SPI-mode-0 master that turns single-cycle read/write requests from the CPU core into complete serial-SRAM transactions on the external pins. It generalises the fixed 8-bit, 16-bit-address memory link used by the SPI CPU:

- address width, data width (burst length) and SCK rate are parameters;
- the CPU side uses a valid/ready request channel plus a response strobe.

It sits between the CPU datapath and the `uio` pin mapping in the top level.

---
 rtl/spi_mem_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/spi_mem_master.sv
// ============================================================================
// Module   : spi_mem_master
// Brief    : SPI mode-0 master that turns one-cycle read/write requests into
//            serial-SRAM frames {cmd, addr, [dummy], data}. Defining the macro
//            SPI_MEM_FAST_READ_EN switches reads to 0x0B plus 8 dummy bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_mem_master #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              spi_cs_n,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

`ifdef SPI_MEM_FAST_READ_EN
    localparam int       DUMMY_W = 8;
    localparam logic [7:0] CMD_RD = 8'h0B;
`else
    localparam int       DUMMY_W = 0;
    localparam logic [7:0] CMD_RD = 8'h03;
`endif
    localparam logic [7:0] CMD_WR = 8'h02;

    localparam int FRAME_W = 8 + ADDR_W + DUMMY_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    // Writes never carry the dummy byte, so they finish DUMMY_W bits earlier.
    localparam logic [CNT_W-1:0] LAST_WR    = CNT_W'(8 + ADDR_W + DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_RD    = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] DATA_START = CNT_W'(8 + ADDR_W + DUMMY_W);
    localparam logic [7:0]       DIV_LAST   = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        CSHIGH = 2'd2
    } state_t;

    state_t               state_q;
    logic [FRAME_W-1:0]   frame_d;
    logic [FRAME_W-1:0]   frame_q;
    logic [DATA_W-1:0]    rx_q;
    logic [DATA_W-1:0]    rdata_q;
    logic [CNT_W-1:0]     bit_q;
    logic [7:0]           div_q;
    logic                 we_q;
    logic                 ready_q;
    logic                 rsp_valid_q;
    logic                 cs_n_q;
    logic                 sck_q;
    logic                 mosi_q;
    logic [CNT_W-1:0]     last_bit;

    // Frame is left-aligned; read dummy/data slots are zero so MOSI idles low.
    always_comb begin
`ifdef SPI_MEM_FAST_READ_EN
        frame_d = req_we ? {CMD_WR, req_addr, req_wdata, 8'h00}
                         : {CMD_RD, req_addr, {(DUMMY_W + DATA_W){1'b0}}};
`else
        frame_d = req_we ? {CMD_WR, req_addr, req_wdata}
                         : {CMD_RD, req_addr, {DATA_W{1'b0}}};
`endif
    end

    assign last_bit = we_q ? LAST_WR : LAST_RD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            bit_q       <= '0;
            div_q       <= '0;
            we_q        <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            cs_n_q      <= 1'b1;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        // MSB goes out immediately; the register holds the rest.
                        mosi_q  <= frame_d[FRAME_W-1];
                        frame_q <= {frame_d[FRAME_W-2:0], 1'b0};
                        we_q    <= req_we;
                        bit_q   <= '0;
                        div_q   <= '0;
                        cs_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        if (!sck_q) begin
                            if (!we_q && (bit_q >= DATA_START))
                                rx_q <= {rx_q[DATA_W-2:0], spi_miso};
                        end else if (bit_q == last_bit) begin
                            cs_n_q      <= 1'b1;
                            mosi_q      <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            if (!we_q)
                                rdata_q <= rx_q;
                            state_q <= CSHIGH;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            mosi_q  <= frame_q[FRAME_W-1];
                            frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
                        end
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                CSHIGH: begin
                    // Hold CS high for CLK_DIV cycles before accepting again.
                    if (div_q == DIV_LAST) begin
                        div_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    cs_n_q  <= 1'b1;
                    sck_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign busy      = ~ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;

endmodule

`default_nettype wire
